shift_sequencer: RTL

- Command-level controller that sits directly upstream of the team's 8-bit shift register (reg_8bit) and drives its d/f inputs.
- Accepts a single command (operand, shift amount, logical/arithmetic mode), issues one load cycle followed by N shift cycles, then captures the register's q output.
- Returns the captured value to the requester with a one-cycle done pulse.

---
 rtl/shift_sequencer_pkg.sv | 17 +
 rtl/shift_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and reg_8bit users:
// register function codes and sequencer state encoding.
package shift_sequencer_pkg;

    localparam logic [1:0] F_HOLD = 2'b00;
    localparam logic [1:0] F_LOAD = 2'b01;
    localparam logic [1:0] F_SHR  = 2'b10;
    localparam logic [1:0] F_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/shift_sequencer.sv
// Command-level controller for the 8-bit shift register: one load,
// N shift cycles, then capture of q with a one-cycle done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic             mode,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] reg_d,
    output logic [1:0]       reg_f,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        res_d   = res_q;
        reg_f   = F_HOLD;
        reg_d   = opnd_q;
        busy    = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    opnd_d  = din;
                    amt_d   = amount;
                    cnt_d   = amount;
                    mode_d  = mode;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                reg_f   = F_LOAD;
                state_d = (amt_q != '0) ? ST_SHIFT : ST_CAPTURE;
            end
            ST_SHIFT: begin
                reg_f = mode_q ? F_ASR : F_SHR;
                cnt_d = cnt_q - AMT_W'(1);
                // Last shift is issued in the cycle the count hits one.
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                done_d  = 1'b1;
                res_d   = q_in;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done   = done_q;
    assign result = res_q;

endmodule
